// File: rtl/counter_seq.sv
// counter_seq - one-shot interval counter started by a single-cycle strobe.
//
// After a start strobe, counts `max` enabled clocks and then emits a
// one-clock completion strobe. Used as the card-detect debounce timer in the
// SD controller top level, but the block itself is generic.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   enable      clock enable; when low, cntr/busy/state hold and strb drops
//   start_strb  single-cycle start request
//   cntr        current count (registered), 0 while idle
//   strb        one-clock completion pulse (registered)
//   busy        high while counting (registered)
//
// Build option:
//   COUNTER_SEQ_RETRIGGER_EN - when defined, a start strobe seen while
//   counting restarts the interval (cntr back to 1, no strb), including on
//   the terminal-count edge. When undefined, such strobes are ignored.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_strb, cntr held at 0
// COUNT | counting enabled clocks up to max, busy high
module counter_seq #(
  parameter int            dw  = 8,
  parameter logic [dw-1:0] max = dw'(8'h27)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          start_strb,
  output logic [dw-1:0] cntr,
  output logic          strb,
  output logic          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t state;
  logic   retrig;

`ifdef COUNTER_SEQ_RETRIGGER_EN
  assign retrig = start_strb;
`else
  assign retrig = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cntr  <= '0;
      strb  <= 1'b0;
      busy  <= 1'b0;
    end else if (!enable) begin
      // Frozen: only the strobe is cleared so it can never stretch.
      strb <= 1'b0;
    end else begin
      strb <= 1'b0;
      case (state)
        IDLE: begin
          if (start_strb) begin
            if (max == '0) begin
              // Zero-length interval completes on the start edge itself.
              cntr <= '0;
              strb <= 1'b1;
            end else begin
              state <= COUNT;
              cntr  <= dw'(1);
              busy  <= 1'b1;
            end
          end else begin
            cntr <= '0;
          end
        end
        COUNT: begin
          // A restart takes precedence over the terminal count.
          if (retrig) begin
            cntr <= dw'(1);
          end else if (cntr == max) begin
            state <= IDLE;
            cntr  <= '0;
            busy  <= 1'b0;
            strb  <= 1'b1;
          end else begin
            cntr <= cntr + dw'(1);
          end
        end
        default: begin
          state <= IDLE;
          cntr  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq.sv
module tb_counter_seq;

`ifdef COUNTER_SEQ_RETRIGGER_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       start_strb = 1'b0;

  logic [7:0] cntr_39, cntr_3, cntr_0;
  logic       strb_39, strb_3, strb_0;
  logic       busy_39, busy_3, busy_0;

  always #5 clk = ~clk;

  counter_seq u_d39 (
    .clk(clk), .reset(reset), .enable(enable), .start_strb(start_strb),
    .cntr(cntr_39), .strb(strb_39), .busy(busy_39)
  );

  counter_seq #(.dw(8), .max(8'd3)) u_d3 (
    .clk(clk), .reset(reset), .enable(enable), .start_strb(start_strb),
    .cntr(cntr_3), .strb(strb_3), .busy(busy_3)
  );

  counter_seq #(.dw(8), .max(8'd0)) u_d0 (
    .clk(clk), .reset(reset), .enable(enable), .start_strb(start_strb),
    .cntr(cntr_0), .strb(strb_0), .busy(busy_0)
  );

  typedef struct {
    string      name;
    int         inst;
    logic [7:0] cntr;
    logic       strb;
    logic       busy;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       en;
    logic       st;
    logic [7:0] c3;
    logic       s3;
    logic       b3;
    logic       s0;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[27];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic expect_out(input string nm, input int inst,
                            input logic [7:0] c, input logic s, input logic b);
    exp_t x;
    x.name = nm; x.inst = inst; x.cntr = c; x.strb = s; x.busy = b;
    sbq.push_back(x);
  endtask

  task automatic check(input exp_t x);
    logic [7:0] ac;
    logic       as, ab;
    case (x.inst)
      39:      begin ac = cntr_39; as = strb_39; ab = busy_39; end
      3:       begin ac = cntr_3;  as = strb_3;  ab = busy_3;  end
      default: begin ac = cntr_0;  as = strb_0;  ab = busy_0;  end
    endcase
    n_checks++;
    if (ac !== x.cntr || as !== x.strb || ab !== x.busy) begin
      n_fail++;
      $display("FAIL %s (max=%0d): got cntr=%0d strb=%b busy=%b, want cntr=%0d strb=%b busy=%b",
               x.name, x.inst, ac, as, ab, x.cntr, x.strb, x.busy);
    end
  endtask

  // Drive one set of inputs, clock once, then compare everything queued.
  task automatic step(input logic r, input logic e, input logic s);
    exp_t x;
    @(negedge clk);
    reset = r; enable = e; start_strb = s;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      check(x);
    end
  endtask

  task automatic do_reset(input string nm);
    expect_out(nm, 39, 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    // rst, en, st, cntr(max=3), strb(max=3), busy(max=3), strb(max=0)
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0};
    tbl[23] = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[24] = '{1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0};
    tbl[25] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[26] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};

    // Short-interval vectors: max=3 and max=0 instances.
    for (int i = 0; i < 27; i++) begin
      expect_out($sformatf("vec%0d", i), 3, tbl[i].c3, tbl[i].s3, tbl[i].b3);
      expect_out($sformatf("vec%0d", i), 0, 8'd0, tbl[i].s0, 1'b0);
      step(tbl[i].rst, tbl[i].en, tbl[i].st);
    end

    // Idle for 100 cycles with no start.
    do_reset("rst_idle");
    for (int k = 0; k < 100; k++) begin
      expect_out("idle", 39, 8'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end

    // Nominal 39-clock interval.
    do_reset("rst_nom");
    for (int k = 0; k <= 45; k++) begin
      if (k < 39)       expect_out("nominal", 39, 8'(k + 1), 1'b0, 1'b1);
      else if (k == 39) expect_out("nominal_strb", 39, 8'd0, 1'b1, 1'b0);
      else              expect_out("nominal_after", 39, 8'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, k == 0);
    end

    // Enable low for 5 cycles mid-count pushes the strobe to E44.
    do_reset("rst_en");
    for (int k = 0; k <= 50; k++) begin
      if (k < 10)       expect_out("en_gap", 39, 8'(k + 1), 1'b0, 1'b1);
      else if (k <= 14) expect_out("en_hold", 39, 8'd10, 1'b0, 1'b1);
      else if (k < 44)  expect_out("en_gap", 39, 8'(k - 4), 1'b0, 1'b1);
      else if (k == 44) expect_out("en_strb", 39, 8'd0, 1'b1, 1'b0);
      else              expect_out("en_after", 39, 8'd0, 1'b0, 1'b0);
      step(1'b0, !(k >= 10 && k <= 14), k == 0);
    end

    // Second start at E10.
    do_reset("rst_retrig");
    for (int k = 0; k <= 55; k++) begin
      if (RT) begin
        if (k < 10)       expect_out("retrig", 39, 8'(k + 1), 1'b0, 1'b1);
        else if (k < 49)  expect_out("retrig", 39, 8'(k - 9), 1'b0, 1'b1);
        else if (k == 49) expect_out("retrig_strb", 39, 8'd0, 1'b1, 1'b0);
        else              expect_out("retrig_after", 39, 8'd0, 1'b0, 1'b0);
      end else begin
        if (k < 39)       expect_out("ignore", 39, 8'(k + 1), 1'b0, 1'b1);
        else if (k == 39) expect_out("ignore_strb", 39, 8'd0, 1'b1, 1'b0);
        else              expect_out("ignore_after", 39, 8'd0, 1'b0, 1'b0);
      end
      step(1'b0, 1'b1, (k == 0) || (k == 10));
    end

    // Reset at count 20 aborts with no strobe.
    do_reset("rst_abort");
    for (int k = 0; k <= 60; k++) begin
      if (k < 20) expect_out("abort_pre", 39, 8'(k + 1), 1'b0, 1'b1);
      else        expect_out("abort_post", 39, 8'd0, 1'b0, 1'b0);
      step(k == 20, 1'b1, k == 0);
    end

    // Start coincident with the terminal-count edge.
    do_reset("rst_coinc");
    for (int k = 0; k <= 41; k++) begin
      if (k < 39)      expect_out("coinc_pre", 39, 8'(k + 1), 1'b0, 1'b1);
      else if (RT)     expect_out("coinc_restart", 39, 8'(k - 38), 1'b0, 1'b1);
      else if (k == 39) expect_out("coinc_strb", 39, 8'd0, 1'b1, 1'b0);
      else             expect_out("coinc_after", 39, 8'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, (k == 0) || (k == 39));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
